// File: rtl/gcd_bus_pkg.sv
// rtl/gcd_bus_pkg.sv - shared constants and encodings for the GCD bus initiator
//
// Purpose: register map defaults, status busy bit, access timing defaults,
// top-level FSM and access-phase encodings, and a counter-width helper.
// Ports: none (package).
package gcd_bus_pkg;

  localparam logic [15:0] DEF_ADDR_A1 = 16'h00d8;
  localparam logic [15:0] DEF_ADDR_A2 = 16'h00dc;
  localparam logic [15:0] DEF_ADDR_W  = 16'h00e0;
  localparam logic [15:0] DEF_ADDR_S  = 16'h00e4;

  localparam int DEF_BUSY_BIT   = 3;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_POLL_GAP   = 4;
  localparam int DEF_MAX_POLLS  = 1024;

  localparam int POLL_W = 11;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_A1     = 4'd1,
    ST_WR_A2     = 4'd2,
    ST_RD_S      = 4'd3,
    ST_POLL_WAIT = 4'd4,
    ST_RD_W      = 4'd5,
    ST_RESP      = 4'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } phase_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_bus_initiator_if.sv
// rtl/gcd_bus_initiator_if.sv - request/response and peripheral bus signal bundle
//
// Purpose: groups the operand request port, result response port, busy flag
// and the saddress/srd/swr/data peripheral bus.
// Modports: master = the initiator, slave = the environment (CPU side + peripheral).
interface gcd_bus_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a1;
  logic [31:0] req_a2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_gcd;
  logic        resp_timeout;
  logic        busy;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    input  req_valid, req_a1, req_a2, resp_ready, bus_rdata,
    output req_ready, resp_valid, resp_gcd, resp_timeout, busy,
           bus_addr, bus_rd, bus_wr, bus_wdata
  );

  modport slave (
    output req_valid, req_a1, req_a2, resp_ready, bus_rdata,
    input  req_ready, resp_valid, resp_gcd, resp_timeout, busy,
           bus_addr, bus_rd, bus_wr, bus_wdata
  );
endinterface

// File: rtl/gcd_bus_access.sv
// rtl/gcd_bus_access.sv - single bus access sequencer (setup / strobe / hold)
//
// Purpose: on i_start, drives one read or write access on the peripheral bus
// and pulses o_done in the last hold cycle; read data is captured at the edge
// ending the last strobe cycle.
// Ports:
//   clk, n_reset          clock, async active-low reset
//   i_start, i_is_read    start an access (only honoured when idle), direction
//   i_addr, i_wdata       access address and write data
//   o_bus_addr/rd/wr/wdata bus pins
//   i_bus_rdata           read data from peripheral
//   o_done, o_rdata       completion pulse, captured read data
module gcd_bus_access
  import gcd_bus_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        i_start,
  input  logic        i_is_read,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata
);

  localparam int MAXC = (SETUP_CYC > STROBE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW = cnt_width(MAXC);

  phase_e        r_phase;
  phase_e        w_phase_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_is_read;
  logic [15:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          w_last;
  logic          w_load;
  logic          w_capture;
  logic          w_clear;

  always_comb begin
    w_last = 1'b0;
    case (r_phase)
      PH_SETUP:  w_last = (r_cnt == CW'(SETUP_CYC - 1));
      PH_STROBE: w_last = (r_cnt == CW'(STROBE_CYC - 1));
      PH_HOLD:   w_last = (r_cnt == CW'(HOLD_CYC - 1));
      default:   w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_phase_nxt = PH_SETUP;
          w_cnt_nxt   = '0;
        end
      end
      PH_SETUP: begin
        if (w_last) begin
          w_phase_nxt = PH_STROBE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PH_STROBE: begin
        if (w_last) begin
          w_phase_nxt = PH_HOLD;
          w_cnt_nxt   = '0;
          w_capture   = r_is_read;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PH_HOLD: begin
        if (w_last) begin
          w_phase_nxt = PH_IDLE;
          w_cnt_nxt   = '0;
          w_clear     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_phase_nxt = PH_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_phase   <= PH_IDLE;
      r_cnt     <= '0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_is_read <= i_is_read;
        r_addr    <= i_addr;
        // Reads keep the data lines at zero.
        r_wdata   <= i_is_read ? 32'd0 : i_wdata;
      end else if (w_clear) begin
        r_addr  <= '0;
        r_wdata <= '0;
      end
      if (w_capture) begin
        r_rdata <= i_bus_rdata;
      end
    end
  end

  // Strobes decode straight from the phase register so a reset drops them
  // without waiting for a clock edge.
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_wdata;
  assign o_bus_rd    = (r_phase == PH_STROBE) &&  r_is_read;
  assign o_bus_wr    = (r_phase == PH_STROBE) && !r_is_read;
  assign o_done      = (r_phase == PH_HOLD) && w_last;
  assign o_rdata     = r_rdata;

endmodule

// File: rtl/gcd_bus_initiator.sv
// rtl/gcd_bus_initiator.sv - bus master that runs one GCD computation per request
//
// Purpose: accepts an operand pair, writes A1 then A2, polls the status
// register until the busy bit clears (or MAX_POLLS reads), reads the result
// and returns it on the response port.
// Ports:
//   clk, n_reset   clock, async active-low reset
//   m              gcd_bus_initiator_if.master: req_*, resp_*, busy, bus_*
module gcd_bus_initiator
  import gcd_bus_pkg::*;
#(
  parameter logic [15:0] ADDR_A1    = DEF_ADDR_A1,
  parameter logic [15:0] ADDR_A2    = DEF_ADDR_A2,
  parameter logic [15:0] ADDR_W     = DEF_ADDR_W,
  parameter logic [15:0] ADDR_S     = DEF_ADDR_S,
  parameter int          BUSY_BIT   = DEF_BUSY_BIT,
  parameter int          SETUP_CYC  = DEF_SETUP_CYC,
  parameter int          STROBE_CYC = DEF_STROBE_CYC,
  parameter int          HOLD_CYC   = DEF_HOLD_CYC,
  parameter int          POLL_GAP   = DEF_POLL_GAP,
  parameter int          MAX_POLLS  = DEF_MAX_POLLS
) (
  input  logic                 clk,
  input  logic                 n_reset,
  gcd_bus_initiator_if.master  m
);

  localparam int GW = cnt_width(POLL_GAP);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_ready_ok;
  logic              r_issued;
  logic [31:0]       r_a1;
  logic [31:0]       r_a2;
  logic [POLL_W-1:0] r_polls;
  logic [POLL_W-1:0] w_polls_inc;
  logic [GW-1:0]     r_gap;
  logic [31:0]       r_resp_gcd;
  logic              r_resp_timeout;

  logic              w_start;
  logic              w_is_read;
  logic [15:0]       w_addr;
  logic [31:0]       w_wdata;
  logic              w_done;
  logic [31:0]       w_rdata;
  logic              w_accept;
  logic              w_poll_done;
  logic              w_resp_ok;
  logic              w_resp_to;

  gcd_bus_access #(
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) u_access (
    .clk         (clk),
    .n_reset     (n_reset),
    .i_start     (w_start),
    .i_is_read   (w_is_read),
    .i_addr      (w_addr),
    .i_wdata     (w_wdata),
    .o_bus_addr  (m.bus_addr),
    .o_bus_rd    (m.bus_rd),
    .o_bus_wr    (m.bus_wr),
    .o_bus_wdata (m.bus_wdata),
    .i_bus_rdata (m.bus_rdata),
    .o_done      (w_done),
    .o_rdata     (w_rdata)
  );

  // Saturating count of status reads including the one finishing now.
  assign w_polls_inc = (r_polls == '1) ? r_polls : r_polls + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_is_read   = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_accept    = 1'b0;
    w_poll_done = 1'b0;
    w_resp_ok   = 1'b0;
    w_resp_to   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ready_ok && m.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WR_A1;
        end
      end
      ST_WR_A1: begin
        w_addr  = ADDR_A1;
        w_wdata = r_a1;
        w_start = !r_issued;
        if (w_done) w_state_nxt = ST_WR_A2;
      end
      ST_WR_A2: begin
        w_addr  = ADDR_A2;
        w_wdata = r_a2;
        w_start = !r_issued;
        if (w_done) w_state_nxt = ST_RD_S;
      end
      ST_RD_S: begin
        w_addr    = ADDR_S;
        w_is_read = 1'b1;
        w_start   = !r_issued;
        if (w_done) begin
          w_poll_done = 1'b1;
          if (!w_rdata[BUSY_BIT]) begin
            w_state_nxt = ST_RD_W;
          end else if ({{(32-POLL_W){1'b0}}, w_polls_inc} >= 32'(MAX_POLLS)) begin
            w_state_nxt = ST_RESP;
            w_resp_to   = 1'b1;
          end else if (POLL_GAP == 0) begin
            w_state_nxt = ST_RD_S;
          end else begin
            w_state_nxt = ST_POLL_WAIT;
          end
        end
      end
      ST_POLL_WAIT: begin
        if (r_gap == GW'(POLL_GAP - 1)) w_state_nxt = ST_RD_S;
      end
      ST_RD_W: begin
        w_addr    = ADDR_W;
        w_is_read = 1'b1;
        w_start   = !r_issued;
        if (w_done) begin
          w_resp_ok   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m.resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state        <= ST_IDLE;
      r_ready_ok     <= 1'b0;
      r_issued       <= 1'b0;
      r_a1           <= '0;
      r_a2           <= '0;
      r_polls        <= '0;
      r_gap          <= '0;
      r_resp_gcd     <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Keeps req_ready low until the first edge after reset release.
      r_ready_ok <= 1'b1;
      // One start per access state; cleared on done so RD_S can re-issue.
      if (w_done) begin
        r_issued <= 1'b0;
      end else if (w_start) begin
        r_issued <= 1'b1;
      end
      if (w_accept) begin
        r_a1    <= m.req_a1;
        r_a2    <= m.req_a2;
        r_polls <= '0;
      end else if (w_poll_done) begin
        r_polls <= w_polls_inc;
      end
      r_gap <= (r_state == ST_POLL_WAIT) ? r_gap + 1'b1 : '0;
      if (w_resp_ok) begin
        r_resp_gcd     <= w_rdata;
        r_resp_timeout <= 1'b0;
      end else if (w_resp_to) begin
        r_resp_gcd     <= '0;
        r_resp_timeout <= 1'b1;
      end
    end
  end

  assign m.req_ready    = r_ready_ok && (r_state == ST_IDLE);
  assign m.resp_valid   = (r_state == ST_RESP);
  assign m.resp_gcd     = r_resp_gcd;
  assign m.resp_timeout = r_resp_timeout;
  assign m.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gcd_bus_initiator.sv
// tb/tb_gcd_bus_initiator.sv - self-checking bench with a behavioural GCD peripheral
module tb_gcd_bus_initiator;

  localparam logic [15:0] A_A1 = 16'h00d8;
  localparam logic [15:0] A_A2 = 16'h00dc;
  localparam logic [15:0] A_W  = 16'h00e0;
  localparam logic [15:0] A_S  = 16'h00e4;
  localparam int SETUP  = 1;
  localparam int STROBE = 2;
  localparam int HOLD   = 1;
  localparam int MAXP   = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic        rd;
    logic [31:0] wdata;
    logic [7:0]  setup;
    logic [7:0]  strobe;
    logic [7:0]  hold;
    logic        stable;
  } acc_t;

  logic clk;
  logic n_reset;
  int   checks = 0;
  int   errors = 0;

  gcd_bus_initiator_if m ();

  gcd_bus_initiator #(.MAX_POLLS(MAXP)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .m       (m.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model and bus monitor state.
  acc_t        log_q[$];
  acc_t        exp_q[$];
  acc_t        cur;
  bit          in_acc = 0;
  int          ph = 0;
  bit          overlap_seen = 0;
  bit          force_busy = 0;
  int          busy_cfg = 0;
  int          p_busy_left = 0;
  logic [31:0] p_a1 = 0;
  logic [31:0] p_a2 = 0;
  logic [31:0] p_res = 0;
  logic [31:0] p_rval = 0;

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a;
    logic [31:0] y = b;
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic acc_t mk(input logic [15:0] addr, input logic rd, input logic [31:0] wd);
    return '{addr, rd, wd, 8'(SETUP), 8'(STROBE), 8'(HOLD), 1'b1};
  endfunction

  // Expected bus traffic for one request: two writes, n_s status reads, optional result read.
  function automatic void build_exp(input logic [31:0] a1, input logic [31:0] a2, input int n_s, input bit with_w);
    exp_q.delete();
    exp_q.push_back(mk(A_A1, 1'b0, a1));
    exp_q.push_back(mk(A_A2, 1'b0, a2));
    for (int i = 0; i < n_s; i++) exp_q.push_back(mk(A_S, 1'b1, 32'd0));
    if (with_w) exp_q.push_back(mk(A_W, 1'b1, 32'd0));
  endfunction

  function automatic int first_diff(output acc_t g, output acc_t e);
    int n = (log_q.size() > exp_q.size()) ? log_q.size() : exp_q.size();
    g = '0;
    e = '0;
    for (int i = 0; i < n; i++) begin
      g = (i < log_q.size()) ? log_q[i] : '0;
      e = (i < exp_q.size()) ? exp_q[i] : '0;
      if (g !== e) return i;
    end
    return -1;
  endfunction

  // Observes the bus mid-cycle, records each access and plays the peripheral.
  always @(negedge clk) begin
    if (!n_reset) begin
      in_acc = 0;
      ph = 0;
      p_a1 = 0;
      p_a2 = 0;
      p_res = 0;
      p_busy_left = 0;
      m.bus_rdata = '0;
    end else begin
      if (m.bus_rd && m.bus_wr) overlap_seen = 1;
      m.bus_rdata = $urandom;
      if (!in_acc && (m.bus_addr != 0 || m.bus_rd || m.bus_wr)) begin
        in_acc = 1;
        ph = 0;
        cur = '{m.bus_addr, 1'b0, m.bus_wdata, 8'd0, 8'd0, 8'd0, 1'b1};
      end
      if (in_acc) begin
        if (m.bus_addr == 0 && !m.bus_rd && !m.bus_wr) begin
          log_q.push_back(cur);
          in_acc = 0;
        end else begin
          if (m.bus_addr !== cur.addr || m.bus_wdata !== cur.wdata) cur.stable = 0;
          if (m.bus_rd || m.bus_wr) begin
            if (ph == 2) cur.stable = 0;
            if (ph == 0) begin
              ph = 1;
              cur.rd = m.bus_rd;
              if (m.bus_wr) begin
                if (m.bus_addr == A_A1) p_a1 = m.bus_wdata;
                else if (m.bus_addr == A_A2) begin
                  p_a2 = m.bus_wdata;
                  p_res = gcd_ref(p_a1, p_a2);
                  p_busy_left = busy_cfg;
                end
              end else begin
                if (m.bus_addr == A_S) begin
                  p_rval = $urandom;
                  p_rval[3] = force_busy || (p_busy_left > 0);
                  if (!force_busy && p_busy_left > 0) p_busy_left = p_busy_left - 1;
                end else if (m.bus_addr == A_W) p_rval = p_res;
                else p_rval = $urandom;
              end
            end
            cur.strobe = cur.strobe + 8'd1;
            // Valid data only in the final strobe cycle; inverted before it.
            if (cur.rd) m.bus_rdata = (cur.strobe == 8'(STROBE)) ? p_rval : ~p_rval;
          end else if (ph == 0) begin
            cur.setup = cur.setup + 8'd1;
          end else begin
            ph = 2;
            cur.hold = cur.hold + 8'd1;
          end
        end
      end
    end
  end

  task automatic send_req(input logic [31:0] a1, input logic [31:0] a2, output bit ok);
    ok = 0;
    @(negedge clk);
    m.req_a1 = a1;
    m.req_a2 = a2;
    m.req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (m.req_ready === 1'b1) begin
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    m.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] g, output logic t, output bit ok);
    ok = 0;
    g = 'x;
    t = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m.resp_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      g = m.resp_gcd;
      t = m.resp_timeout;
      m.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      m.resp_ready = 1'b0;
    end
  endtask

  task automatic do_request(input logic [31:0] a1, input logic [31:0] a2, output logic [31:0] g, output logic t, output bit ok);
    bit ok1;
    log_q.delete();
    send_req(a1, a2, ok1);
    if (ok1) wait_resp(g, t, ok);
    else begin
      ok = 0;
      g = 'x;
      t = 1'bx;
    end
  endtask

  task automatic test_reset();
    logic [85:0] v;
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    v = {m.req_ready, m.resp_valid, m.resp_gcd, m.resp_timeout, m.busy, m.bus_addr, m.bus_rd, m.bus_wr, m.bus_wdata};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v); end
    #2 n_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", m.req_ready); end
    checks++;
    if ({m.bus_addr, m.bus_rd, m.bus_wr, m.bus_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus_idle: addr %h rd %b wr %b wdata %h want all 0", m.bus_addr, m.bus_rd, m.bus_wr, m.bus_wdata);
    end
    checks++;
    if ({m.resp_valid, m.busy, m.resp_timeout, m.resp_gcd} !== '0) begin
      errors++; $display("FAIL reset_resp: valid %b busy %b to %b gcd %h want 0", m.resp_valid, m.busy, m.resp_timeout, m.resp_gcd);
    end
  endtask

  // Runs one request and checks the result and the full bus transcript.
  task automatic run_and_check(input string tag, input logic [31:0] a1, input logic [31:0] a2, input int bcfg, input bit fb);
    logic [31:0] g;
    logic t;
    bit ok;
    int d;
    acc_t ga, ea;
    busy_cfg = bcfg;
    force_busy = fb;
    do_request(a1, a2, g, t, ok);
    force_busy = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_handshake: request or response not seen within bound", tag); end
    checks++;
    if (g !== (fb ? 32'd0 : gcd_ref(a1, a2))) begin
      errors++; $display("FAIL %s_gcd: got %0d want %0d (a1=%0d a2=%0d)", tag, g, fb ? 32'd0 : gcd_ref(a1, a2), a1, a2);
    end
    checks++;
    if (t !== fb) begin errors++; $display("FAIL %s_timeout: got %b want %b", tag, t, fb); end
    build_exp(a1, a2, fb ? MAXP : bcfg + 1, !fb);
    d = first_diff(ga, ea);
    checks++;
    if (d !== -1) begin
      errors++; $display("FAIL %s_accesses: entry %0d got %h want %h (count %0d want %0d)", tag, d, ga, ea, log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_basic();
    run_and_check("basic_48_18", 32'd48, 32'd18, 3, 0);
  endtask

  task automatic test_zero_operands();
    run_and_check("zero_7_0", 32'd7, 32'd0, 0, 0);
    run_and_check("zero_0_0", 32'd0, 32'd0, 2, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b, c;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        c = $urandom_range(1, 500);
        a = c * $urandom_range(1, 5000);
        b = c * $urandom_range(1, 5000);
      end else begin
        a = $urandom;
        b = $urandom;
      end
      run_and_check($sformatf("random%0d", k), a, b, $urandom_range(0, 6), 0);
    end
  endtask

  task automatic test_poll_limit();
    run_and_check("poll_last", 32'd1071, 32'd462, MAXP - 1, 0);
  endtask

  task automatic test_timeout();
    run_and_check("timeout", 32'd100, 32'd75, 0, 1);
  endtask

  task automatic test_resp_stall();
    bit ok, stable;
    logic [31:0] g0, g;
    logic t0, t;
    int n;
    busy_cfg = 1;
    log_q.delete();
    send_req(32'd84, 32'd36, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_accept: request not accepted"); end
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m.resp_valid === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_resp_seen: resp_valid not seen within bound"); end
    g0 = m.resp_gcd;
    t0 = m.resp_timeout;
    checks++;
    if (g0 !== 32'd12 || t0 !== 1'b0) begin errors++; $display("FAIL stall_gcd: got %0d to %b want 12 to 0", g0, t0); end
    m.req_a1 = 32'd35;
    m.req_a2 = 32'd21;
    m.req_valid = 1'b1;
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m.resp_valid !== 1'b1 || m.resp_gcd !== g0 || m.resp_timeout !== t0 || m.req_ready !== 1'b0 || m.busy !== 1'b1) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL stall_hold: valid %b gcd %0d ready %b busy %b want 1 %0d 0 1", m.resp_valid, m.resp_gcd, m.req_ready, m.busy, g0);
    end
    m.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    m.resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({m.resp_valid, m.req_ready, m.busy} !== 3'b010) begin
      errors++; $display("FAIL stall_after_hs: valid/ready/busy got %b want 010", {m.resp_valid, m.req_ready, m.busy});
    end
    checks++;
    if (m.resp_gcd !== g0) begin errors++; $display("FAIL stall_gcd_hold: got %0d want %0d", m.resp_gcd, g0); end
    @(posedge clk);
    #1;
    m.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m.busy !== 1'b1) begin errors++; $display("FAIL stall_next_accept: busy got %b want 1", m.busy); end
    wait_resp(g, t, ok);
    checks++;
    if (!ok || g !== gcd_ref(32'd35, 32'd21) || t !== 1'b0) begin
      errors++; $display("FAIL stall_second: ok %b gcd %0d to %b want 1 %0d 0", ok, g, t, gcd_ref(32'd35, 32'd21));
    end
    n = 0;
    foreach (log_q[i]) if (log_q[i].addr == A_W) n++;
    checks++;
    if (n !== 2) begin errors++; $display("FAIL stall_w_reads: got %0d want 2", n); end
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    logic [85:0] v;
    busy_cfg = 2;
    log_q.delete();
    send_req(32'd60, 32'd45, ok);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m.bus_wr === 1'b1 && m.bus_addr === A_A2) begin found = 1; break; end
    end
    checks++;
    if (!ok || !found) begin errors++; $display("FAIL rstmid_reach: accepted %b strobe_seen %b want 1 1", ok, found); end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if (m.bus_wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr_drop: got %b want 0", m.bus_wr); end
    v = {m.req_ready, m.resp_valid, m.resp_gcd, m.resp_timeout, m.busy, m.bus_addr, m.bus_rd, m.bus_wr, m.bus_wdata};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", v); end
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m.req_ready !== 1'b1 || m.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: ready %b busy %b want 1 0", m.req_ready, m.busy);
    end
    run_and_check("rstmid_after", 32'd270, 32'd192, 1, 0);
  endtask

  initial begin
    n_reset = 1'b0;
    m.req_valid = 1'b0;
    m.req_a1 = '0;
    m.req_a2 = '0;
    m.resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_operands();
    test_random();
    test_poll_limit();
    test_timeout();
    test_resp_stall();
    test_reset_mid();
    checks++;
    if (overlap_seen !== 1'b0) begin errors++; $display("FAIL strobe_exclusive: rd and wr high together seen %b want 0", overlap_seen); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
